// File: rtl/hsv_core_trap_seq.sv
// Trap and flush sequencer for the hsv_core commit stage: arbitrates traps, mret,
// explicit flushes, interrupts and wfi, and drives the global flush handshake.

package hsv_core_trap_seq_pkg;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned CAUSE_W = 5;
    typedef logic [CAUSE_W-1:0] exception_t;
endpackage

module hsv_core_trap_seq
    import hsv_core_trap_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk_core,
    input  logic             rst_core_n,
    input  logic             ctrl_flush_begin,
    input  logic             ctrl_commit,
    input  logic             ctrl_trap,
    input  logic             ctrl_mode_return,
    input  logic             ctrl_wait_irq,
    input  exception_t       ctrl_trap_cause,
    input  logic [XLEN-1:0]  ctrl_trap_value,
    input  logic [XLEN-1:0]  ctrl_next_pc,
    output logic             ctrl_begin_irq,
    input  logic             irq_pending_i,
    input  exception_t       irq_cause_i,
    input  logic [XLEN-1:0]  mtvec_i,
    input  logic [XLEN-1:0]  mepc_i,
    output logic             flush_req,
    output logic [XLEN-1:0]  flush_target,
    input  logic             flush_ack_i,
    output logic             trap_o,
    output logic             trap_irq_o,
    output exception_t       trap_cause_o,
    output logic [XLEN-1:0]  trap_value_o,
    output logic [XLEN-1:0]  trap_epc_o,
    output logic             mret_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        RELEASE = 2'd2,
        WFI     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            flush_req_q, flush_req_d;
    logic [XLEN-1:0] flush_target_q, flush_target_d;
    logic            trap_q, trap_d;
    logic            trap_irq_q, trap_irq_d;
    exception_t      trap_cause_q, trap_cause_d;
    logic [XLEN-1:0] trap_value_q, trap_value_d;
    logic [XLEN-1:0] trap_epc_q, trap_epc_d;
    logic            mret_q, mret_d;
    logic            flush_pend_q, flush_pend_d;
    logic            irq_pend_q, irq_pend_d;
    logic            take_irq;

    // Next-state and registered-output computation; flush_pend/irq_pend hold what commit saw last cycle
    always_comb begin
        state_d        = state_q;
        flush_target_d = flush_target_q;
        trap_d         = 1'b0;
        trap_irq_d     = 1'b0;
        mret_d         = 1'b0;
        trap_cause_d   = trap_cause_q;
        trap_value_d   = trap_value_q;
        trap_epc_d     = trap_epc_q;
        flush_pend_d   = 1'b0;
        irq_pend_d     = 1'b0;
        ctrl_begin_irq = 1'b0;
        take_irq       = 1'b0;

        case (state_q)
            RUN: begin
                ctrl_begin_irq = irq_pending_i;
                flush_pend_d   = ctrl_flush_begin & ctrl_commit;
                irq_pend_d     = irq_pending_i;
                if (ctrl_trap) begin
                    trap_d         = 1'b1;
                    trap_cause_d   = ctrl_trap_cause;
                    trap_value_d   = ctrl_trap_value;
                    trap_epc_d     = ctrl_next_pc;
                    flush_target_d = mtvec_i;
                    state_d        = FLUSH;
                end else if (ctrl_mode_return) begin
                    mret_d         = 1'b1;
                    flush_target_d = mepc_i;
                    state_d        = FLUSH;
                end else if (flush_pend_q) begin
                    flush_target_d = ctrl_next_pc;
                    state_d        = FLUSH;
                end else if (irq_pend_q) begin
                    take_irq = 1'b1;
                end else if (ctrl_wait_irq) begin
                    state_d = WFI;
                end
            end
            WFI: begin
                ctrl_begin_irq = irq_pending_i;
                irq_pend_d     = irq_pending_i;
                take_irq       = irq_pend_q;
            end
            FLUSH: begin
                if (flush_ack_i) state_d = RELEASE;
            end
            RELEASE: begin
                if (!flush_ack_i) state_d = RUN;
            end
            default: state_d = FLUSH;
        endcase

        if (take_irq) begin
            trap_d         = 1'b1;
            trap_irq_d     = 1'b1;
            trap_cause_d   = irq_cause_i;
            trap_value_d   = '0;
            trap_epc_d     = ctrl_next_pc;
            flush_target_d = mtvec_i;
            state_d        = FLUSH;
        end

        flush_req_d = (state_d == FLUSH);
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q        <= FLUSH;
            flush_req_q    <= 1'b1;
            flush_target_q <= RESET_PC;
            trap_q         <= 1'b0;
            trap_irq_q     <= 1'b0;
            trap_cause_q   <= '0;
            trap_value_q   <= '0;
            trap_epc_q     <= '0;
            mret_q         <= 1'b0;
            flush_pend_q   <= 1'b0;
            irq_pend_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_req_q    <= flush_req_d;
            flush_target_q <= flush_target_d;
            trap_q         <= trap_d;
            trap_irq_q     <= trap_irq_d;
            trap_cause_q   <= trap_cause_d;
            trap_value_q   <= trap_value_d;
            trap_epc_q     <= trap_epc_d;
            mret_q         <= mret_d;
            flush_pend_q   <= flush_pend_d;
            irq_pend_q     <= irq_pend_d;
        end
    end

    assign flush_req    = flush_req_q;
    assign flush_target = flush_target_q;
    assign trap_o       = trap_q;
    assign trap_irq_o   = trap_irq_q;
    assign trap_cause_o = trap_cause_q;
    assign trap_value_o = trap_value_q;
    assign trap_epc_o   = trap_epc_q;
    assign mret_o       = mret_q;

endmodule

// File: tb/tb_hsv_core_trap_seq.sv
// Self-checking bench for hsv_core_trap_seq: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural reference model.

module tb_hsv_core_trap_seq;
    import hsv_core_trap_seq_pkg::*;

    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam int PH_RUN = 0, PH_FLUSH = 1, PH_REL = 2, PH_WFI = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic ctrl_flush_begin, ctrl_commit, ctrl_trap, ctrl_mode_return, ctrl_wait_irq;
    exception_t ctrl_trap_cause, irq_cause_i, trap_cause_o;
    logic [31:0] ctrl_trap_value, ctrl_next_pc, mtvec_i, mepc_i;
    logic ctrl_begin_irq, irq_pending_i, flush_req, flush_ack_i;
    logic [31:0] flush_target, trap_value_o, trap_epc_o;
    logic trap_o, trap_irq_o, mret_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 0;
    bit auto_ack = 0;

    always #5 clk = ~clk;

    hsv_core_trap_seq #(.RESET_PC(RPC)) dut (
        .clk_core(clk), .rst_core_n(rst_n),
        .ctrl_flush_begin(ctrl_flush_begin), .ctrl_commit(ctrl_commit),
        .ctrl_trap(ctrl_trap), .ctrl_mode_return(ctrl_mode_return), .ctrl_wait_irq(ctrl_wait_irq),
        .ctrl_trap_cause(ctrl_trap_cause), .ctrl_trap_value(ctrl_trap_value),
        .ctrl_next_pc(ctrl_next_pc), .ctrl_begin_irq(ctrl_begin_irq),
        .irq_pending_i(irq_pending_i), .irq_cause_i(irq_cause_i),
        .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .flush_req(flush_req), .flush_target(flush_target), .flush_ack_i(flush_ack_i),
        .trap_o(trap_o), .trap_irq_o(trap_irq_o), .trap_cause_o(trap_cause_o),
        .trap_value_o(trap_value_o), .trap_epc_o(trap_epc_o), .mret_o(mret_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase plus what commit observed one cycle ago
    int ph;
    bit saw_flush, saw_irq;
    logic e_req, e_trap, e_irq, e_mret;
    logic [31:0] e_tgt, e_val, e_epc;
    exception_t e_cause;

    always @(posedge clk or negedge rst_n) begin : model
        int  winner;
        bit  obs_flush, obs_irq;
        if (!rst_n) begin
            ph = PH_FLUSH; e_req = 1; e_tgt = RPC;
            e_trap = 0; e_irq = 0; e_mret = 0; e_cause = '0; e_val = 0; e_epc = 0;
            saw_flush = 0; saw_irq = 0;
        end else begin
            obs_flush = (ph == PH_RUN) && ctrl_flush_begin && ctrl_commit;
            obs_irq   = (ph == PH_RUN || ph == PH_WFI) && irq_pending_i;
            e_trap = 0; e_irq = 0; e_mret = 0;
            winner = 0;
            if (ph == PH_RUN) begin
                if (ctrl_trap)             winner = 1;
                else if (ctrl_mode_return) winner = 2;
                else if (saw_flush)        winner = 3;
                else if (saw_irq)          winner = 4;
                else if (ctrl_wait_irq)    winner = 5;
            end else if (ph == PH_WFI) begin
                if (saw_irq) winner = 4;
            end else if (ph == PH_FLUSH) begin
                if (flush_ack_i) ph = PH_REL;
            end else if (!flush_ack_i) begin
                ph = PH_RUN;
            end
            case (winner)
                1: begin e_trap = 1; e_cause = ctrl_trap_cause; e_val = ctrl_trap_value;
                         e_epc = ctrl_next_pc; e_tgt = mtvec_i; ph = PH_FLUSH; end
                2: begin e_mret = 1; e_tgt = mepc_i; ph = PH_FLUSH; end
                3: begin e_tgt = ctrl_next_pc; ph = PH_FLUSH; end
                4: begin e_trap = 1; e_irq = 1; e_cause = irq_cause_i; e_val = 0;
                         e_epc = ctrl_next_pc; e_tgt = mtvec_i; ph = PH_FLUSH; end
                5: ph = PH_WFI;
                default: ;
            endcase
            saw_flush = obs_flush;
            saw_irq   = obs_irq;
            e_req     = (ph == PH_FLUSH);
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_flush_req", 32'(flush_req), 32'(e_req));
            chk("m_flush_target", flush_target, e_tgt);
            chk("m_trap_o", 32'(trap_o), 32'(e_trap));
            chk("m_trap_irq_o", 32'(trap_irq_o), 32'(e_irq));
            chk("m_mret_o", 32'(mret_o), 32'(e_mret));
            chk("m_begin_irq", 32'(ctrl_begin_irq),
                32'(rst_n && (ph == PH_RUN || ph == PH_WFI) && irq_pending_i));
            if (e_trap) begin
                chk("m_trap_cause", 32'(trap_cause_o), 32'(e_cause));
                chk("m_trap_value", trap_value_o, e_val);
                chk("m_trap_epc", trap_epc_o, e_epc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_ack) begin
            if (flush_req && !flush_ack_i && $urandom_range(2) == 0) flush_ack_i = 1;
            else if (!flush_req && flush_ack_i && $urandom_range(1) == 0) flush_ack_i = 0;
        end
    endtask

    task automatic do_ack();
        flush_ack_i = 1;
        step();
        chk("rel_flush_req", 32'(flush_req), 32'd0);
        chk("rel_begin_irq", 32'(ctrl_begin_irq), 32'd0);
        flush_ack_i = 0;
        step();
    endtask

    task automatic clear_ctrl();
        ctrl_flush_begin = 0; ctrl_commit = 0; ctrl_trap = 0;
        ctrl_mode_return = 0; ctrl_wait_irq = 0;
    endtask

    initial begin
        rst_n = 0; clear_ctrl(); irq_pending_i = 0; flush_ack_i = 0;
        ctrl_trap_cause = '0; irq_cause_i = '0; ctrl_trap_value = 0;
        ctrl_next_pc = 0; mtvec_i = 0; mepc_i = 0;
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1;
        chk("rst_flush_req", 32'(flush_req), 32'd1);
        chk("rst_target", flush_target, RPC);
        chk("rst_trap_o", 32'(trap_o), 32'd0);
        chk("rst_mret_o", 32'(mret_o), 32'd0);
        chk("rst_epc", trap_epc_o, 32'd0);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_hold_req", 32'(flush_req), 32'd1);
            chk("rst_hold_target", flush_target, RPC);
        end
        do_ack();

        // interrupt in RUN, pending drops before the decision cycle
        ctrl_commit = 1; ctrl_next_pc = 32'h44; irq_pending_i = 1; mtvec_i = 32'h200;
        #1 chk("irq_begin_same_cycle", 32'(ctrl_begin_irq), 32'd1);
        step();
        irq_pending_i = 0; ctrl_commit = 0; irq_cause_i = exception_t'(7);
        step();
        chk("irq_trap_o", 32'(trap_o), 32'd1);
        chk("irq_trap_irq", 32'(trap_irq_o), 32'd1);
        chk("irq_epc", trap_epc_o, 32'h44);
        chk("irq_cause", 32'(trap_cause_o), 32'd7);
        chk("irq_value", trap_value_o, 32'd0);
        chk("irq_target", flush_target, 32'h200);
        do_ack();

        // synchronous trap
        ctrl_commit = 1; ctrl_flush_begin = 1;
        step();
        clear_ctrl(); ctrl_trap = 1; ctrl_trap_cause = exception_t'(2);
        ctrl_trap_value = 32'hDEAD; ctrl_next_pc = 32'h100; mtvec_i = 32'h200;
        step();
        ctrl_trap = 0;
        chk("trap_o", 32'(trap_o), 32'd1);
        chk("trap_irq", 32'(trap_irq_o), 32'd0);
        chk("trap_epc", trap_epc_o, 32'h100);
        chk("trap_cause", 32'(trap_cause_o), 32'd2);
        chk("trap_value", trap_value_o, 32'hDEAD);
        chk("trap_target", flush_target, 32'h200);
        chk("trap_req", 32'(flush_req), 32'd1);
        step();
        chk("trap_pulse_once", 32'(trap_o), 32'd0);
        chk("trap_req_hold", 32'(flush_req), 32'd1);
        do_ack();

        // mret with a pending interrupt: mret wins, interrupt retaken after RUN
        ctrl_commit = 1; ctrl_flush_begin = 1; irq_pending_i = 1; mepc_i = 32'h300;
        ctrl_next_pc = 32'h104; irq_cause_i = exception_t'(11);
        step();
        clear_ctrl(); ctrl_mode_return = 1;
        step();
        ctrl_mode_return = 0;
        chk("mret_o", 32'(mret_o), 32'd1);
        chk("mret_no_trap", 32'(trap_o), 32'd0);
        chk("mret_target", flush_target, 32'h300);
        do_ack();
        step(); step();
        chk("mret_irq_trap", 32'(trap_o), 32'd1);
        chk("mret_irq_flag", 32'(trap_irq_o), 32'd1);
        chk("mret_irq_epc", trap_epc_o, 32'h104);
        irq_pending_i = 0;
        do_ack();

        // WFI: no flush while waiting, interrupt wakes it
        ctrl_commit = 1;
        step();
        ctrl_commit = 0; ctrl_wait_irq = 1;
        step();
        ctrl_wait_irq = 0;
        for (int i = 0; i < 10; i++) begin
            chk("wfi_no_req", 32'(flush_req), 32'd0);
            step();
        end
        irq_pending_i = 1; ctrl_next_pc = 32'h80; irq_cause_i = exception_t'(3);
        #1 chk("wfi_begin_irq", 32'(ctrl_begin_irq), 32'd1);
        step();
        irq_pending_i = 0;
        step();
        chk("wfi_trap_o", 32'(trap_o), 32'd1);
        chk("wfi_epc", trap_epc_o, 32'h80);
        chk("wfi_cause", 32'(trap_cause_o), 32'd3);
        do_ack();

        // reset asserted mid-flush
        ctrl_trap = 1; ctrl_trap_cause = exception_t'(2); mtvec_i = 32'h200;
        step();
        ctrl_trap = 0;
        step();
        chk("mid_pre_target", flush_target, 32'h200);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_target", flush_target, RPC);
        chk("mid_rst_req", 32'(flush_req), 32'd1);
        step();
        rst_n = 1;
        step();
        chk("mid_rst_hold", flush_target, RPC);
        do_ack();

        // randomized traffic with a protocol-following ack responder
        auto_ack = 1;
        for (int c = 0; c < 4000; c++) begin
            ctrl_commit      = ($urandom_range(1) == 0);
            ctrl_flush_begin = ($urandom_range(3) == 0);
            ctrl_trap        = ($urandom_range(9) == 0);
            ctrl_mode_return = ($urandom_range(11) == 0);
            ctrl_wait_irq    = ($urandom_range(7) == 0);
            if ($urandom_range(3) == 0) irq_pending_i = ~irq_pending_i;
            ctrl_trap_cause  = exception_t'($urandom);
            irq_cause_i      = exception_t'($urandom);
            ctrl_trap_value  = $urandom;
            ctrl_next_pc     = $urandom;
            if ($urandom_range(7) == 0) mtvec_i = $urandom;
            if ($urandom_range(7) == 0) mepc_i = $urandom;
            if ($urandom_range(499) == 0) begin
                #2 rst_n = 0;
                step();
                rst_n = 1;
            end else begin
                step();
            end
        end
        auto_ack = 0;
        clear_ctrl();
        step();
        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
